// File: rtl/lsu_load_path_if.sv
// Load-path bus bundle: EXU request, AXI read-wrapper host side, WBU result.
// Latency: none (wires only).
// Backpressure: carries LD_Valid/LD_Ready and WB_Valid/WB_Ready handshakes; the read side is request/finish.
// Ports (slave = load unit):
//   LD_*      EXU load request (valid/ready, 64-bit address, funct3, tag)
//   R_*       read address/request to the AXI read wrapper, R_Finish/Data_Out back
//   WB_*      extended load result to WBU (valid/ready, data, tag, error)
interface lsu_load_path_if #(
  parameter int TAG_W = 5
);
  logic             LD_Valid;
  logic             LD_Ready;
  logic [63:0]      LD_Addr;
  logic [2:0]       LD_Funct3;
  logic [TAG_W-1:0] LD_Tag;

  logic [63:0]      R_Addr;
  logic             R_Request;
  logic             R_Finish;
  logic [63:0]      Data_Out;

  logic             WB_Valid;
  logic             WB_Ready;
  logic [63:0]      WB_Data;
  logic [TAG_W-1:0] WB_Tag;
  logic             WB_Err;

  // Load unit side.
  modport slave (
    input  LD_Valid, LD_Addr, LD_Funct3, LD_Tag,
    output LD_Ready,
    output R_Addr, R_Request,
    input  R_Finish, Data_Out,
    output WB_Valid, WB_Data, WB_Tag, WB_Err,
    input  WB_Ready
  );

  // Environment side (EXU, read wrapper and WBU together).
  modport master (
    output LD_Valid, LD_Addr, LD_Funct3, LD_Tag,
    input  LD_Ready,
    input  R_Addr, R_Request,
    output R_Finish, Data_Out,
    input  WB_Valid, WB_Data, WB_Tag, WB_Err,
    output WB_Ready
  );
endinterface

// File: rtl/lsu_load_path.sv
// LSU load path: accepts one load, issues an 8-byte-aligned read, extracts and extends the addressed field.
// Latency: accept t -> R_Request t+1; R_Finish f -> WB_Valid f+1; error loads -> WB_Valid t+1.
// Backpressure: LD_Ready only in IDLE; result held stable in RESP until WB_Ready.
// Ports:
//   CLK, RST  clock and asynchronous active-high reset
//   bus       lsu_load_path_if.slave (LD_* request, R_* read wrapper, WB_* result)
module lsu_load_path #(
  parameter int TAG_W       = 5,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  lsu_load_path_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       off_q;
  logic [2:0]       f3_q;
  logic [TAG_W-1:0] tag_in;
  logic             misaligned;
  logic             bad_load;
  logic [63:0]      sh;
  logic [63:0]      ext;

  assign tag_in       = bus.LD_Tag;
  assign bus.LD_Ready = (state == IDLE);

  // Alignment is judged on the incoming request so the error path never touches memory.
  always_comb begin
    misaligned = 1'b0;
    case (bus.LD_Funct3[1:0])
      2'b01:   misaligned = bus.LD_Addr[0];
      2'b10:   misaligned = (bus.LD_Addr[1:0] != 2'b00);
      2'b11:   misaligned = (bus.LD_Addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
    bad_load = (bus.LD_Funct3 == 3'b111) || (ALIGN_CHECK && misaligned);
  end

  // Extraction uses the captured offset; with alignment checking off the low
  // offset bits still select the field, matching natural-alignment placement.
  always_comb begin
    sh  = bus.Data_Out >> {off_q, 3'b000};
    ext = 64'd0;
    case (f3_q)
      3'b000:  ext = {{56{sh[7]}},  sh[7:0]};
      3'b001:  ext = {{48{sh[15]}}, sh[15:0]};
      3'b010:  ext = {{32{sh[31]}}, sh[31:0]};
      3'b011:  ext = bus.Data_Out;
      3'b100:  ext = {56'd0, sh[7:0]};
      3'b101:  ext = {48'd0, sh[15:0]};
      3'b110:  ext = {32'd0, sh[31:0]};
      default: ext = 64'd0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      off_q         <= 3'd0;
      f3_q          <= 3'd0;
      bus.R_Request <= 1'b0;
      bus.R_Addr    <= 64'd0;
      bus.WB_Valid  <= 1'b0;
      bus.WB_Data   <= 64'd0;
      bus.WB_Tag    <= '0;
      bus.WB_Err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.LD_Valid) begin
            off_q      <= bus.LD_Addr[2:0];
            f3_q       <= bus.LD_Funct3;
            // WB_Valid is low outside RESP, so the tag can be loaded at accept.
            bus.WB_Tag <= tag_in;
            if (bad_load) begin
              bus.WB_Err   <= 1'b1;
              bus.WB_Data  <= 64'd0;
              bus.WB_Valid <= 1'b1;
              state        <= RESP;
            end else begin
              bus.WB_Err    <= 1'b0;
              bus.R_Request <= 1'b1;
              bus.R_Addr    <= {bus.LD_Addr[63:3], 3'b000};
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.R_Finish) begin
            bus.R_Request <= 1'b0;
            bus.WB_Data   <= ext;
            bus.WB_Valid  <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.WB_Ready) begin
            bus.WB_Valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_load_path.sv
// Directed bench for lsu_load_path: reset, extraction/extension, error path, backpressure, latency.
// Latency: inputs driven and outputs checked on the falling edge.
// Backpressure: WB_Ready held low for a programmable number of cycles per load.
module tb_lsu_load_path;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  lsu_load_path_if #(.TAG_W(5)) bus ();

  lsu_load_path #(
    .TAG_W       (5),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the unit idle.
  // fin_wait: cycles of R_Request before R_Finish (0 = finish in its first cycle).
  // bp: cycles WB_Ready stays low once the result is valid.
  task automatic run_load(input string nm, input logic [63:0] addr, input logic [2:0] f3,
                          input logic [4:0] tag, input logic [63:0] dout, input logic exp_err,
                          input logic [63:0] exp_data, input int fin_wait, input int bp);
    chk({nm, ".ld_ready"}, {63'd0, bus.LD_Ready}, 64'd1);
    bus.LD_Valid  = 1'b1;
    bus.LD_Addr   = addr;
    bus.LD_Funct3 = f3;
    bus.LD_Tag    = tag;
    @(negedge CLK);
    bus.LD_Valid = 1'b0;
    bus.LD_Addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.LD_Tag   = 5'h1F;
    chk({nm, ".busy"}, {63'd0, bus.LD_Ready}, 64'd0);
    if (exp_err) begin
      chk({nm, ".no_req"}, {63'd0, bus.R_Request}, 64'd0);
    end else begin
      chk({nm, ".req"}, {63'd0, bus.R_Request}, 64'd1);
      chk({nm, ".raddr"}, bus.R_Addr, {addr[63:3], 3'b000});
      for (int i = 0; i < fin_wait; i++) begin
        @(negedge CLK);
        chk({nm, ".req_hold"}, {63'd0, bus.R_Request}, 64'd1);
        chk({nm, ".wait_novld"}, {63'd0, bus.WB_Valid}, 64'd0);
      end
      bus.R_Finish = 1'b1;
      bus.Data_Out = dout;
      @(negedge CLK);
      bus.R_Finish = 1'b0;
      bus.Data_Out = 64'h5A5A_5A5A_5A5A_5A5A;
      chk({nm, ".req_drop"}, {63'd0, bus.R_Request}, 64'd0);
    end
    chk({nm, ".wb_vld"}, {63'd0, bus.WB_Valid}, 64'd1);
    chk({nm, ".wb_data"}, bus.WB_Data, exp_data);
    chk({nm, ".wb_err"}, {63'd0, bus.WB_Err}, {63'd0, exp_err});
    chk({nm, ".wb_tag"}, {59'd0, bus.WB_Tag}, {59'd0, tag});
    // A competing request offered while busy must not be captured.
    bus.LD_Valid  = (bp > 0);
    bus.LD_Addr   = 64'h0000_0000_0000_0040;
    bus.LD_Funct3 = 3'b011;
    bus.LD_Tag    = ~tag;
    for (int i = 0; i < bp; i++) begin
      @(negedge CLK);
      chk({nm, ".bp_vld"}, {63'd0, bus.WB_Valid}, 64'd1);
      chk({nm, ".bp_data"}, bus.WB_Data, exp_data);
      chk({nm, ".bp_tag"}, {59'd0, bus.WB_Tag}, {59'd0, tag});
      chk({nm, ".bp_ldrdy"}, {63'd0, bus.LD_Ready}, 64'd0);
    end
    bus.LD_Valid = 1'b0;
    bus.WB_Ready = 1'b1;
    @(negedge CLK);
    bus.WB_Ready = 1'b0;
    chk({nm, ".wb_done"}, {63'd0, bus.WB_Valid}, 64'd0);
    chk({nm, ".idle"}, {63'd0, bus.LD_Ready}, 64'd1);
    chk({nm, ".idle_req"}, {63'd0, bus.R_Request}, 64'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    RST           = 1'b1;
    bus.LD_Valid  = 1'b0;
    bus.LD_Addr   = 64'd0;
    bus.LD_Funct3 = 3'd0;
    bus.LD_Tag    = 5'd0;
    bus.R_Finish  = 1'b0;
    bus.Data_Out  = 64'd0;
    bus.WB_Ready  = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst.ld_ready", {63'd0, bus.LD_Ready}, 64'd1);
    chk("rst.r_req", {63'd0, bus.R_Request}, 64'd0);
    chk("rst.r_addr", bus.R_Addr, 64'd0);
    chk("rst.wb_vld", {63'd0, bus.WB_Valid}, 64'd0);
    chk("rst.wb_data", bus.WB_Data, 64'd0);
    chk("rst.wb_tag", {59'd0, bus.WB_Tag}, 64'd0);
    chk("rst.wb_err", {63'd0, bus.WB_Err}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Reset while a read is outstanding: request drops without a clock edge.
    bus.LD_Valid  = 1'b1;
    bus.LD_Addr   = 64'h0000_0000_8000_0010;
    bus.LD_Funct3 = 3'b011;
    bus.LD_Tag    = 5'h03;
    @(negedge CLK);
    bus.LD_Valid = 1'b0;
    chk("midreq.req", {63'd0, bus.R_Request}, 64'd1);
    #2 RST = 1'b1;
    #1 chk("midreq.async_drop", {63'd0, bus.R_Request}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    bus.R_Finish = 1'b1;
    bus.Data_Out = 64'h0000_0000_0000_DEAD;
    @(negedge CLK);
    bus.R_Finish = 1'b0;
    chk("stray.wb_vld", {63'd0, bus.WB_Valid}, 64'd0);
    chk("stray.ld_ready", {63'd0, bus.LD_Ready}, 64'd1);

    run_load("lb_sign", 64'h0000_0000_8000_0005, 3'b000, 5'h15, 64'h0011_8000_0000_0000,
             1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
    run_load("lhu", 64'h0000_0000_8000_0006, 3'b101, 5'h06, 64'hBEEF_0000_0000_0000,
             1'b0, 64'h0000_0000_0000_BEEF, 2, 0);
    run_load("lwu", 64'h0000_0000_8000_0004, 3'b110, 5'h07, 64'hBEEF_0000_0000_0000,
             1'b0, 64'h0000_0000_BEEF_0000, 1, 0);
    run_load("lh_sign", 64'h0000_0000_8000_0002, 3'b001, 5'h09, 64'h0000_0000_8765_0000,
             1'b0, 64'hFFFF_FFFF_FFFF_8765, 0, 0);
    run_load("lw_sign", 64'h0000_0000_8000_0004, 3'b010, 5'h0A, 64'h8000_0001_0000_0000,
             1'b0, 64'hFFFF_FFFF_8000_0001, 3, 1);
    run_load("lbu", 64'h1234_5678_9ABC_DEF1, 3'b100, 5'h0B, 64'h0000_0000_0000_FF00,
             1'b0, 64'h0000_0000_0000_00FF, 1, 0);
    run_load("mis_lw", 64'h0000_0000_8000_0002, 3'b010, 5'h11, 64'd0,
             1'b1, 64'd0, 0, 0);

    // Stray finish after an error response is ignored.
    bus.R_Finish = 1'b1;
    bus.Data_Out = 64'h0000_0000_0000_DEAD;
    @(negedge CLK);
    bus.R_Finish = 1'b0;
    chk("stray2.wb_vld", {63'd0, bus.WB_Valid}, 64'd0);
    chk("stray2.r_req", {63'd0, bus.R_Request}, 64'd0);

    run_load("bad_f3", 64'h0000_0000_8000_0000, 3'b111, 5'h12, 64'd0,
             1'b1, 64'd0, 0, 0);
    run_load("bp_ld", 64'h0000_0000_8000_0008, 3'b011, 5'h1C, 64'h1122_3344_5566_7788,
             1'b0, 64'h1122_3344_5566_7788, 2, 5);
    run_load("same_cyc", 64'h0000_0000_8000_0018, 3'b011, 5'h01, 64'h0123_4567_89AB_CDEF,
             1'b0, 64'h0123_4567_89AB_CDEF, 0, 0);

    // Reset while a result is pending discards it.
    bus.LD_Valid  = 1'b1;
    bus.LD_Addr   = 64'h0000_0000_8000_0003;
    bus.LD_Funct3 = 3'b011;
    bus.LD_Tag    = 5'h0F;
    @(negedge CLK);
    bus.LD_Valid = 1'b0;
    chk("midresp.vld", {63'd0, bus.WB_Valid}, 64'd1);
    RST = 1'b1;
    #1 chk("midresp.drop", {63'd0, bus.WB_Valid}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midresp.idle", {63'd0, bus.LD_Ready}, 64'd1);
    chk("midresp.err", {63'd0, bus.WB_Err}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_load_path.md
Name: lsu_load_path

Overview:
- Load-path stage in the LSU, directly upstream of the AXI4-lite read wrapper. Drives its host-side R_Addr/R_Request and consumes R_Finish/Data_Out.
- Accepts one load request at a time from EXU: 64-bit byte address, RISC-V funct3, destination tag.
- Issues an 8-byte-aligned read, then extracts the addressed byte/half/word/dword and sign- or zero-extends it.
- Returns the result to WBU over a valid/ready handshake.

Parameters:
TAG_W, 5, width of destination-register tag carried with each load
ALIGN_CHECK, 1, 1 = misaligned loads flagged as error without a memory read; 0 = offset bits ignored (natural-alignment extraction still uses addr[2:0])

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
LD_Valid  in  1  EXU load request valid
LD_Ready  out  1  unit can accept a request
LD_Addr  in  64  byte address
LD_Funct3  in  3  load type
LD_Tag  in  TAG_W  destination tag
R_Addr  out  64  read address to AXI read wrapper, always 8-byte aligned
R_Request  out  1  read request to AXI read wrapper
R_Finish  in  1  one-cycle pulse: read data valid
Data_Out  in  64  read data, valid when R_Finish=1
WB_Valid  out  1  result valid
WB_Ready  in  1  WBU accepts result
WB_Data  out  64  extended load result
WB_Tag  out  TAG_W  tag of result
WB_Err  out  1  misaligned or illegal-funct3 load

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - LD_Ready=1 (combinational from state). R_Request=0, R_Addr=0.
  - WB_Valid=0, WB_Data=0, WB_Tag=0, WB_Err=0.
- States: IDLE, REQ, RESP. All outputs except LD_Ready are registered.
- IDLE:
  - LD_Ready=1.
  - On LD_Valid: capture LD_Addr, LD_Funct3, LD_Tag.
  - If funct3=111, or ALIGN_CHECK=1 and misaligned: go to RESP with WB_Err=1, WB_Data=0. No memory access.
  - Otherwise: go to REQ, with R_Request=1 and R_Addr={LD_Addr[63:3],3'b000} registered.
- Misalignment rules, using off=addr[2:0]:
  - LH/LHU: off[0]!=0.
  - LW/LWU: off[1:0]!=0.
  - LD: off!=0.
  - LB/LBU: never misaligned.
- REQ:
  - R_Request and R_Addr held stable until the R_Finish cycle.
  - On R_Finish: R_Request deasserts the next cycle. Data_Out is sampled; WB_Data is computed and registered; go to RESP.
  - No timeout.
- Extraction: sh = Data_Out >> (off*8).
  - 000 LB: sext(sh[7:0]).
  - 001 LH: sext(sh[15:0]).
  - 010 LW: sext(sh[31:0]).
  - 011 LD: Data_Out.
  - 100 LBU: zext(sh[7:0]).
  - 101 LHU: zext(sh[15:0]).
  - 110 LWU: zext(sh[31:0]).
- RESP:
  - WB_Valid=1. WB_Data, WB_Tag, WB_Err held stable while WB_Ready=0.
  - On WB_Ready: WB_Valid=0 the next cycle; go to IDLE.
  - LD_Ready=0 in REQ and RESP. No back-to-back accept in the handoff cycle.
- Latency:
  - Accept at cycle t → R_Request=1 at t+1.
  - R_Finish at cycle f → WB_Valid=1 at f+1.
  - Error path: WB_Valid=1 at t+1.
- Boundaries:
  - R_Finish in IDLE or RESP is ignored. Covers a stray pulse after reset or after an error.
  - R_Finish in the same cycle R_Request first rises is legal and completes normally.
  - RST mid-REQ: R_Request drops immediately (async); the in-flight read is abandoned.
  - RST mid-RESP: the pending result is discarded.
  - LD_Valid while LD_Ready=0 is not captured; EXU holds it.
  - Address bits [63:3] pass through unmodified; no wrap logic.

Test Plan:
- Reset mid-REQ: assert RST while R_Request=1 → R_Request=0 in the same cycle. After release, a stray R_Finish with Data_Out=0xDEAD leaves WB_Valid=0 and LD_Ready=1.
- LB sign: LD_Addr=0x8000_0005, funct3=000, Data_Out=0x0011_8000_0000_0000 → R_Addr=0x8000_0000, WB_Data=0xFFFF_FFFF_FFFF_FF80, WB_Err=0, tag echoed.
- LHU/LWU zero-extend: addr=...06, funct3=101, Data_Out=0xBEEF_0000_0000_0000 → WB_Data=0x0000_0000_0000_BEEF. Then addr=...04, funct3=110, same data → 0x0000_0000_BEEF_0000.
- Misaligned LW: addr=0x8000_0002, funct3=010, ALIGN_CHECK=1 → R_Request never rises; WB_Valid at t+1 with WB_Err=1, WB_Data=0. Repeat with funct3=111 → same response.
- Backpressure: LD result ready with WB_Ready=0 for 5 cycles → WB_Valid, WB_Data, WB_Tag stable; LD_Ready=0. WB_Ready=1 → IDLE next cycle; next LD_Valid accepted.
- Same-cycle finish and latency: R_Finish coincident with the first R_Request cycle, Data_Out=0x0123_4567_89AB_CDEF, LD → WB_Valid=1 exactly one cycle later with WB_Data=0x0123_4567_89AB_CDEF.
